// File: rtl/twiddle_gen.sv
// twiddle_gen: W_N^n = cos(2pi n/N) - j sin(2pi n/N), optionally conjugated, from a quarter-wave cosine table.
// Two-stage stallable valid/ready pipe. Build option TWIDDLE_GEN_ZERO_UNITY_EN: n=0 returns 0+j0.
module twiddle_gen #(
   parameter int N     = 64,
   parameter int WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [$clog2(N)-1:0]    taddr,
   input  logic                    inverse,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        tdata_r,
   output logic [WIDTH-1:0]        tdata_i
);

   localparam int NN    = $clog2(N);
   localparam int QTR_I = N / 4;
   localparam logic [NN-2:0] QTR = QTR_I[NN-2:0];
   localparam longint TWO_PI_Q30 = 64'sd6746518852;

   // Quarter-wave entry cq[k] = min(round(cos(2pi k/N) * 2^(WIDTH-1)), 2^(WIDTH-1)-1),
   // evaluated at elaboration with a Q30 Taylor series so every table word is a constant.
   function automatic logic [WIDTH-2:0] cq_val(input int k);
      longint x, x2, term, sum, v, maxv;
      x    = (TWO_PI_Q30 * longint'(k)) / longint'(N);
      x2   = (x * x) >>> 30;
      term = 64'sd1 <<< 30;
      sum  = term;
      for (int m = 1; m <= 12; m++) begin
         term = -((term * x2) >>> 30) / longint'((2 * m - 1) * (2 * m));
         sum  = sum + term;
      end
      maxv = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
      v    = (sum + (64'sd1 <<< (30 - WIDTH))) >>> (31 - WIDTH);
      if (v > maxv) v = maxv;
      if (v < 0)    v = 0;
      return v[WIDTH-2:0];
   endfunction

   logic [WIDTH-2:0] rom_w [0:QTR_I];

   for (genvar g = 0; g <= QTR_I; g++) begin : g_rom
      assign rom_w[g] = cq_val(g);
   end

   logic             en;
   logic [NN-3:0]    k_w;
   logic [NN-2:0]    idx_a, idx_b;

   logic             v1_q;
   logic [1:0]       q1_q;
   logic             inv1_q;
   logic [WIDTH-2:0] a_q, b_q;
`ifdef TWIDDLE_GEN_ZERO_UNITY_EN
   logic             zero1_q;
`endif

   logic                    out_valid_q;
   logic signed [WIDTH-1:0] tdata_r_q, tdata_i_q;
   logic signed [WIDTH-1:0] tdata_r_d, tdata_i_d;
   logic signed [WIDTH-1:0] a_s, b_s;

   assign en       = out_ready | ~out_valid_q;
   assign in_ready = en;

   assign k_w   = taddr[NN-3:0];
   assign idx_a = {1'b0, k_w};
   assign idx_b = QTR - idx_a;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1_q    <= 1'b0;
         q1_q    <= '0;
         inv1_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
`ifdef TWIDDLE_GEN_ZERO_UNITY_EN
         zero1_q <= 1'b0;
`endif
      end else if (en) begin
         v1_q    <= in_valid;
         q1_q    <= taddr[NN-1:NN-2];
         inv1_q  <= inverse;
         a_q     <= rom_w[idx_a];
         b_q     <= rom_w[idx_b];
`ifdef TWIDDLE_GEN_ZERO_UNITY_EN
         zero1_q <= (taddr == '0);
`endif
      end
   end

   assign a_s = {1'b0, a_q};
   assign b_s = {1'b0, b_q};

   // Table words are non-negative and below 2^(WIDTH-1), so each negation is exact and -0 folds to 0.
   // NOTE: both outputs get a default first so no path through the block leaves a latch.
   always_comb begin
      tdata_r_d = a_s;
      tdata_i_d = -b_s;
      unique case (q1_q)
         2'd0: begin tdata_r_d =  a_s; tdata_i_d = -b_s; end
         2'd1: begin tdata_r_d = -b_s; tdata_i_d = -a_s; end
         2'd2: begin tdata_r_d = -a_s; tdata_i_d =  b_s; end
         2'd3: begin tdata_r_d =  b_s; tdata_i_d =  a_s; end
      endcase
      if (inv1_q) tdata_i_d = -tdata_i_d;
`ifdef TWIDDLE_GEN_ZERO_UNITY_EN
      if (zero1_q) begin
         tdata_r_d = '0;
         tdata_i_d = '0;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         tdata_r_q   <= '0;
         tdata_i_q   <= '0;
      end else if (en) begin
         out_valid_q <= v1_q;
         tdata_r_q   <= tdata_r_d;
         tdata_i_q   <= tdata_i_d;
      end
   end

   assign out_valid = out_valid_q;
   assign tdata_r   = tdata_r_q;
   assign tdata_i   = tdata_i_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (N=64, WIDTH=16): latency, fold/conjugate values, stalls, sweep, reset flush.
module tb_twiddle_gen;

   localparam real PI = 3.14159265358979323846;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  taddr;
   logic        inverse;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] tdata_r;
   logic [15:0] tdata_i;

   int n_total = 0;
   int n_bad   = 0;

   bit sb_on   = 0;
   bit rand_on = 0;
   int n_pop   = 0;
   logic [15:0] exp_r_q [$];
   logic [15:0] exp_i_q [$];

   twiddle_gen #(.N(64), .WIDTH(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .taddr     (taddr),
      .inverse   (inverse),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .tdata_r   (tdata_r),
      .tdata_i   (tdata_i)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] er, input logic [15:0] ei);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_r"}, 32'(tdata_r), 32'(er));
      check({tag, "_i"}, 32'(tdata_i), 32'(ei));
   endtask

   // One isolated request with out_ready=1; result is checked two cycles after issue.
   task automatic single(input string tag, input int n, input bit inv,
                         input logic [15:0] er, input logic [15:0] ei);
      in_valid = 1'b1;
      taddr    = 6'(n);
      inverse  = inv;
      tick();
      in_valid = 1'b0;
      tick();
      expect_out(tag, er, ei);
   endtask

   function automatic logic [15:0] model_part(input int n, input bit imag);
      real ang, x;
      int  v;
      ang = -2.0 * PI * real'(n) / 64.0;
      x   = imag ? 32768.0 * $sin(ang) : 32768.0 * $cos(ang);
      v   = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
      if (v > 32767)  v = 32767;
      if (v < -32767) v = -32767;
`ifdef TWIDDLE_GEN_ZERO_UNITY_EN
      if (n == 0) v = 0;
`endif
      return v[15:0];
   endfunction

   task automatic push_req(input int n);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      taddr    = 6'(n);
      inverse  = 1'b0;
      for (int c = 0; c < 200 && !accepted; c++) begin
         @(negedge clock);
         if (in_ready) begin
            exp_r_q.push_back(model_part(n, 1'b0));
            exp_i_q.push_back(model_part(n, 1'b1));
            accepted = 1'b1;
         end
         @(posedge clock);
         #1;
      end
      if (!accepted) check("sweep_accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_on) out_ready = ($urandom_range(0, 99) >= 30);
      end
   end

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   initial begin
      bit          held;
      logic [15:0] held_r, held_i;
      int          d;
      held = 1'b0;
      forever begin
         @(negedge clock);
         if (!sb_on) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_r", 32'(tdata_r), 32'(held_r));
               check("stall_i", 32'(tdata_i), 32'(held_i));
            end
            held = out_valid && !out_ready;
            held_r = tdata_r;
            held_i = tdata_i;
            if (out_valid && out_ready) begin
               if (exp_r_q.size() == 0) begin
                  check("sweep_extra_output", 32'(n_pop), 32'd64);
               end else begin
                  d = $signed(tdata_r) - $signed(exp_r_q.pop_front());
                  if (d < 0) d = -d;
                  check("sweep_r_lsb_err", (d <= 1) ? 32'd0 : 32'(d), 32'd0);
                  d = $signed(tdata_i) - $signed(exp_i_q.pop_front());
                  if (d < 0) d = -d;
                  check("sweep_i_lsb_err", (d <= 1) ? 32'd0 : 32'(d), 32'd0);
               end
               n_pop++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      taddr     = '0;
      inverse   = 1'b0;
      out_ready = 1'b1;

      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_r", 32'(tdata_r), 32'd0);
      check("rst_i", 32'(tdata_i), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Latency of one request: nothing after the accept edge, result after the next.
      in_valid = 1'b1;
      taddr    = 6'd8;
      tick();
      in_valid = 1'b0;
      check("t1_lat_valid", 32'(out_valid), 32'd0);
      tick();
      expect_out("t1_n8", 16'h5A82, 16'hA57E);
      tick();
      check("t1_after_valid", 32'(out_valid), 32'd0);

      // Back-to-back stream, one result per cycle in order.
      in_valid = 1'b1;
      taddr    = 6'd33;
      tick();
      taddr = 6'd45;
      check("t2_lat_valid", 32'(out_valid), 32'd0);
      tick();
      taddr = 6'd16;
      expect_out("t2_n33", 16'h809E, 16'h0C8C);
      tick();
      in_valid = 1'b0;
      expect_out("t2_n45", 16'hDAD8, 16'h7A7D);
      tick();
      expect_out("t2_n16", 16'h0000, 16'h8001);
      tick();
      check("t2_after_valid", 32'(out_valid), 32'd0);

      // Conjugate, quadrant boundaries, zero handling and address wrap.
      single("t3_n8_inv", 8, 1'b1, 16'h5A82, 16'h5A82);
`ifdef TWIDDLE_GEN_ZERO_UNITY_EN
      single("t3_n0", 0, 1'b0, 16'h0000, 16'h0000);
      single("t3_n0_inv", 0, 1'b1, 16'h0000, 16'h0000);
`else
      single("t3_n0", 0, 1'b0, 16'h7FFF, 16'h0000);
      single("t3_n0_inv", 0, 1'b1, 16'h7FFF, 16'h0000);
`endif
      single("t3_n16_inv", 16, 1'b1, 16'h0000, 16'h7FFF);
      single("t3_n32", 32, 1'b0, 16'h8001, 16'h0000);
      single("t3_n48", 48, 1'b0, 16'h0000, 16'h7FFF);
      single("t3_n63", 63, 1'b0, 16'h7F62, 16'h0C8C);
      tick();

      // Stall: output holds, in_ready drops, a waiting request is taken only once en returns.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      taddr     = 6'd8;
      tick();
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      taddr    = 6'd33;
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
      taddr = 6'd45;
      expect_out("hold_n8_a", 16'h5A82, 16'hA57E);
      tick();
      expect_out("hold_n8_b", 16'h5A82, 16'hA57E);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("hold_bubble_valid", 32'(out_valid), 32'd0);
      tick();
      expect_out("hold_n45", 16'hDAD8, 16'h7A7D);
      tick();

      // Full sweep against the cos/sin model with random back-pressure.
      n_pop   = 0;
      sb_on   = 1'b1;
      rand_on = 1'b1;
      for (int n = 0; n < 64; n++) push_req(n);
      in_valid  = 1'b0;
      rand_on   = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 300 && exp_r_q.size() != 0; c++) tick();
      tick();
      tick();
      sb_on = 1'b0;
      check("sweep_count", 32'(n_pop), 32'd64);
      check("sweep_left", 32'(exp_r_q.size()), 32'd0);

      // Reset with two requests in flight flushes everything.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      taddr     = 6'd33;
      tick();
      taddr = 6'd45;
      tick();
      in_valid = 1'b0;
      check("t5_pre_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_valid", 32'(out_valid), 32'd0);
      check("t5_rst_r", 32'(tdata_r), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t5_no_stale_a", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      taddr    = 6'd8;
      tick();
      in_valid = 1'b0;
      check("t5_lat_valid", 32'(out_valid), 32'd0);
      tick();
      expect_out("t5_n8", 16'h5A82, 16'hA57E);
      tick();
      check("t5_no_stale_b", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
